dfr_capture_ctrl: RTL and testbench

DFR_CAPTURE_CTRL -- requirements
Module: dfr_capture_ctrl

---
 rtl/dfr_pkg.sv | 16 +
 rtl/dfr_capture_ctrl_if.sv | 36 +++
 rtl/dfr_capture_ctrl_cnt.sv | 22 ++
 rtl/dfr_capture_ctrl.sv | 106 ++++++++++
 tb/tb_dfr_capture_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/dfr_pkg.sv
// dfr_pkg: shared definitions for the capture controller.
//   state_t      : capture FSM encoding (IDLE / CAPTURE / DONE)
//   DFR_*        : default parameter values for address, data and period widths
package dfr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  localparam int DFR_ADDR_W   = 20;
  localparam int DFR_DATA_W   = 32;
  localparam int DFR_PERIOD_W = 16;

endpackage

// File: rtl/dfr_capture_ctrl_if.sv
// dfr_capture_ctrl_if: history-RAM port plus the readback request port.
//   ram_wen/ram_addr/ram_din -> RAM, ram_dout <- RAM (1-cycle synchronous read)
//   rd_req/rd_addr           -> controller, rd_grant/rd_valid/rd_data <- controller
//   master: controller side, slave: RAM + readback requester side.
interface dfr_capture_ctrl_if
  import dfr_pkg::*;
#(
  parameter int ADDR_WIDTH = DFR_ADDR_W,
  parameter int DATA_WIDTH = DFR_DATA_W
) ();

  logic                  ram_wen;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [DATA_WIDTH-1:0] ram_dout;
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_grant;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (
    output ram_wen, ram_addr, ram_din,
    input  ram_dout,
    input  rd_req, rd_addr,
    output rd_grant, rd_valid, rd_data
  );

  modport slave (
    input  ram_wen, ram_addr, ram_din,
    output ram_dout,
    output rd_req, rd_addr,
    input  rd_grant, rd_valid, rd_data
  );

endinterface

// File: rtl/dfr_capture_ctrl_cnt.sv
// dfr_capture_ctrl_cnt: clearable up-counter used for sample_count.
//   S_AXI_ACLK/S_AXI_ARESETN : clock, async active-low reset
//   i_clr : synchronous clear (wins over i_inc)
//   i_inc : increment by one
//   o_cnt : current count
module dfr_capture_ctrl_cnt #(
  parameter int W = 21
) (
  input  logic         S_AXI_ACLK,
  input  logic         S_AXI_ARESETN,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN)  o_cnt <= '0;
    else if (i_clr)      o_cnt <= '0;
    else if (i_inc)      o_cnt <= o_cnt + W'(1);
  end

endmodule

// File: rtl/dfr_capture_ctrl.sv
// dfr_capture_ctrl: writes one reservoir sample into the history RAM every
// (sample_period+1) cycles until num_samples have been stored, and shares the
// RAM port with a readback requester (capture writes always win).
//   S_AXI_ACLK, S_AXI_ARESETN : clock, async active-low reset
//   start, abort              : run control pulses
//   num_samples, sample_period: run configuration, latched on start
//   din                       : sample to store
//   busy, done, sample_count  : status
//   bus (master)              : RAM port + readback port
module dfr_capture_ctrl
  import dfr_pkg::*;
#(
  parameter int ADDR_WIDTH   = DFR_ADDR_W,
  parameter int DATA_WIDTH   = DFR_DATA_W,
  parameter int PERIOD_WIDTH = DFR_PERIOD_W
) (
  input  logic                    S_AXI_ACLK,
  input  logic                    S_AXI_ARESETN,
  input  logic                    start,
  input  logic                    abort,
  input  logic [ADDR_WIDTH:0]     num_samples,
  input  logic [PERIOD_WIDTH-1:0] sample_period,
  input  logic [DATA_WIDTH-1:0]   din,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_WIDTH:0]     sample_count,
  dfr_capture_ctrl_if.master      bus
);

  localparam logic [ADDR_WIDTH:0] MAX_N = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE_N = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                  r_state, w_state_nxt;
  logic [ADDR_WIDTH:0]     r_num;
  logic [PERIOD_WIDTH-1:0] r_period, r_pcnt;
  logic                    r_rd_vld;
  logic                    w_start, w_tick, w_wen, w_last, w_grant;
  logic [ADDR_WIDTH:0]     w_num_clamp;

  // start is only honoured outside CAPTURE; abort has no meaning there.
  assign w_start     = start & (r_state != ST_CAPTURE);
  assign w_num_clamp = (num_samples > MAX_N) ? MAX_N : num_samples;
  assign w_tick      = (r_pcnt == r_period);
  // abort squashes a write landing in the same cycle
  assign w_wen       = (r_state == ST_CAPTURE) & w_tick & ~abort;
  assign w_last      = w_wen & (sample_count == r_num - ONE_N);
  assign w_grant     = bus.rd_req & ~w_wen;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) r_state <= ST_IDLE;
    else                r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE:
        if (start) w_state_nxt = (num_samples == '0) ? ST_DONE : ST_CAPTURE;
      ST_CAPTURE:
        if (abort)       w_state_nxt = ST_IDLE;
        else if (w_last) w_state_nxt = ST_DONE;
      default:           w_state_nxt = ST_IDLE;
    endcase
  end

  // config latch and period counter; the counter wraps on each write slot
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_num    <= '0;
      r_period <= '0;
      r_pcnt   <= '0;
    end else if (w_start) begin
      r_num    <= w_num_clamp;
      r_period <= sample_period;
      r_pcnt   <= '0;
    end else if (r_state == ST_CAPTURE) begin
      r_pcnt   <= w_tick ? '0 : r_pcnt + PERIOD_WIDTH'(1);
    end
  end

  dfr_capture_ctrl_cnt #(.W(ADDR_WIDTH+1)) u_cnt (
    .S_AXI_ACLK    (S_AXI_ACLK),
    .S_AXI_ARESETN (S_AXI_ARESETN),
    .i_clr         (w_start),
    .i_inc         (w_wen),
    .o_cnt         (sample_count)
  );

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) r_rd_vld <= 1'b0;
    else                r_rd_vld <= w_grant;
  end

  assign busy = (r_state == ST_CAPTURE);
  // done is sticky exactly as long as the FSM sits in DONE
  assign done = (r_state == ST_DONE);

  assign bus.ram_wen  = w_wen;
  assign bus.ram_din  = din;
  assign bus.ram_addr = w_wen   ? sample_count[ADDR_WIDTH-1:0] :
                        w_grant ? bus.rd_addr : '0;
  assign bus.rd_grant = w_grant;
  assign bus.rd_valid = r_rd_vld;
  assign bus.rd_data  = bus.ram_dout;

endmodule

// File: tb/tb_dfr_capture_ctrl.sv
module tb_dfr_capture_ctrl;
  localparam int AW = 4, DW = 16, PW = 4, DEPTH = 16;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [AW:0]   num_samples = '0;
  logic [PW-1:0] sample_period = '0;
  logic [DW-1:0] din = '0;
  logic          busy, done;
  logic [AW:0]   sample_count;

  dfr_capture_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  dfr_capture_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PERIOD_WIDTH(PW)) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .start         (start),
    .abort         (abort),
    .num_samples   (num_samples),
    .sample_period (sample_period),
    .din           (din),
    .busy          (busy),
    .done          (done),
    .sample_count  (sample_count),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // history RAM: read-first, 1-cycle read latency
  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] exp_mem [DEPTH];
  always @(posedge clk) begin
    if (bus.ram_wen) mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= mem[bus.ram_addr];
  end

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s @cyc %0d: observed=%0h expected=%0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // One capture run, checked cycle by cycle against the write schedule
  // implied by (n, per): write k lands (per+1)*(k+1) cycles after start.
  // abort_k >= 0 aborts in the cycle of write k. sdur re-pulses start mid-run.
  // rd_hold raises rd_req at start and keeps it until granted.
  task automatic run(input int n, input int per, input int abort_k,
                     input bit sdur, input bit rd_hold, input int raddr);
    int S, A, E, neff, nw, k;
    bit rd_on, prev_g, wr, g;
    logic [DW-1:0] prev_d;
    step();
    S     = cyc;
    neff  = (n > DEPTH) ? DEPTH : n;
    nw    = (abort_k >= 0) ? abort_k : neff;
    A     = (abort_k >= 0) ? S + (per + 1) * (abort_k + 1) : -1;
    if (abort_k >= 0)   E = A + 1;
    else if (neff == 0) E = S + 1;
    else                E = S + (per + 1) * neff + 1;
    rd_on = rd_hold; prev_g = 1'b0; prev_d = '0;
    for (int c = S; c <= E + 1; c++) begin
      if (c != S) step();
      din   = DW'($urandom);
      start = (c == S) || (sdur && c == S + 2 && c <= E - 1);
      if (c == S) begin
        num_samples   = (AW+1)'(n);
        sample_period = PW'(per);
      end else if (start) begin
        num_samples   = (AW+1)'($urandom);
        sample_period = PW'($urandom);
      end
      abort       = (c == A);
      bus.rd_req  = rd_on;
      bus.rd_addr = AW'(raddr);
      #2;
      wr = 1'b0; k = 0;
      if (c > S && (c - S) % (per + 1) == 0) begin
        k  = (c - S) / (per + 1) - 1;
        wr = (k < nw);
      end
      g = rd_on && !wr;
      chk("ram_wen", bus.ram_wen, wr);
      chk("rd_grant", bus.rd_grant, g);
      chk("ram_addr", bus.ram_addr, wr ? k : (g ? raddr : 0));
      if (wr) begin
        chk("ram_din", bus.ram_din, din);
        exp_mem[k] = din;
      end
      chk("busy", busy, (c > S && c < E));
      chk("rd_valid", bus.rd_valid, prev_g);
      if (prev_g) chk("rd_data", bus.rd_data, prev_d);
      if (c == E) begin
        chk("done", done, abort_k < 0);
        chk("sample_count", sample_count, nw);
      end
      prev_g = g;
      if (g) begin prev_d = exp_mem[raddr]; rd_on = 1'b0; end
    end
    start = 1'b0; abort = 1'b0; bus.rd_req = 1'b0;
  endtask

  task automatic rd_idle(input int a);
    step();
    bus.rd_req = 1'b1; bus.rd_addr = AW'(a);
    #2;
    chk("idle_grant", bus.rd_grant, 1);
    chk("idle_addr", bus.ram_addr, a);
    step();
    bus.rd_req = 1'b0;
    #2;
    chk("idle_valid", bus.rd_valid, 1);
    chk("idle_data", bus.rd_data, exp_mem[a]);
  endtask

  initial begin
    int n, per, ak, S;
    for (int i = 0; i < DEPTH; i++) begin mem[i] = '0; exp_mem[i] = '0; end
    bus.rd_req = 1'b0; bus.rd_addr = '0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", sample_count, 0);
    chk("rst_wen", bus.ram_wen, 0);
    chk("rst_valid", bus.rd_valid, 0);
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); #2;
      chk("idle_busy", busy, 0);
      chk("idle_wen", bus.ram_wen, 0);
    end

    run(4, 0, -1, 0, 0, 0);   // back-to-back writes
    run(3, 2, -1, 0, 0, 0);   // writes three cycles apart
    run(4, 0, -1, 0, 1, 2);   // readback starved until DONE
    run(8, 0, 1, 0, 0, 0);    // abort on 2nd write
    run(0, 1, -1, 0, 0, 0);   // zero samples
    run(6, 1, -1, 1, 0, 0);   // start mid-run ignored
    run(20, 0, -1, 0, 0, 0);  // clamped to RAM depth
    rd_idle(7);

    for (int it = 0; it < 8; it++) begin
      n   = $urandom_range(0, 20);
      per = $urandom_range(0, 3);
      ak  = -1;
      if (n > 0 && $urandom_range(0, 3) == 0)
        ak = $urandom_range(0, ((n > DEPTH) ? DEPTH : n) - 1);
      run(n, per, ak, 1'($urandom), 1'($urandom), $urandom_range(0, DEPTH - 1));
    end
    rd_idle($urandom_range(0, DEPTH - 1));

    // reset in the middle of a period-1 run after two writes
    step();
    S = cyc;
    start = 1'b1; num_samples = 5'd8; sample_period = 4'd1; din = DW'($urandom);
    step(); start = 1'b0; din = DW'($urandom);
    step(); din = DW'($urandom); #2;
    chk("mid_wen0", bus.ram_wen, 1);
    chk("mid_addr0", bus.ram_addr, 0);
    exp_mem[0] = din;
    step(); din = DW'($urandom); #2;
    chk("mid_gap", bus.ram_wen, 0);
    step(); din = DW'($urandom); #2;
    chk("mid_wen1", bus.ram_wen, 1);
    exp_mem[1] = din;
    step(); #2;
    chk("mid_count", sample_count, 2);
    chk("mid_cyc", cyc - S, 5);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_count", sample_count, 0);
    chk("arst_wen", bus.ram_wen, 0);
    chk("arst_valid", bus.rd_valid, 0);
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 3) rst_n = 1'b1;
      din = DW'($urandom);
      #2;
      chk("post_rst_wen", bus.ram_wen, 0);
      chk("post_rst_busy", busy, 0);
    end
    rd_idle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
